// File: rtl/hamming_secded_decoder.sv
// SEC-DED decoder for 16 data + 6 check bits. It has a two-stage pipeline with valid/ready handshaking on both sides.
// Defining HAMMING_ERR_COUNT_EN builds the saturating error counters; without it err_*_cnt read 0 and cnt_clr is ignored.
module hamming_secded_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [5:0]       in_check,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [4:0]       out_syndrome,
    output logic             out_err_single,
    output logic             out_err_double,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_single_cnt,
    output logic [CNT_W-1:0] err_double_cnt
);

    // Codeword position of each data bit; powers of two hold the check bits.
    localparam logic [4:0] DPOS [16] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
    };

    logic        advance;
    logic [4:0]  calc_c;
    logic [4:0]  syn_d;
    logic        par_d;

    logic        s1_valid;
    logic [15:0] s1_data;
    logic [4:0]  s1_syn;
    logic        s1_par;

    logic [15:0] fix_mask;
    logic        dec_single;
    logic        dec_double;
    logic [15:0] dec_data;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance || rst;

    always_comb begin
        calc_c = '0;
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 5; b++) begin
                calc_c[b] = calc_c[b] ^ (in_data[i] & DPOS[i][b]);
            end
        end
        syn_d = calc_c ^ in_check[4:0];
        par_d = ^{in_data, in_check};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_syn   <= syn_d;
            s1_par   <= par_d;
        end
    end

    // Odd overall parity with a syndrome inside the codeword is one flipped bit.
    // Syndrome 0 or a check-bit position means the data is already correct.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            fix_mask[i] = (DPOS[i] == s1_syn);
        end
        dec_single = s1_par && (s1_syn <= 5'd21);
        dec_double = (!s1_par && (s1_syn != 5'd0)) || (s1_par && (s1_syn > 5'd21));
        dec_data   = dec_single ? (s1_data ^ fix_mask) : s1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_syndrome   <= '0;
            out_err_single <= 1'b0;
            out_err_double <= 1'b0;
        end else if (advance) begin
            out_valid      <= s1_valid;
            out_data       <= dec_data;
            out_syndrome   <= s1_syn;
            out_err_single <= s1_valid && dec_single;
            out_err_double <= s1_valid && dec_double;
        end
    end

`ifdef HAMMING_ERR_COUNT_EN
    logic             out_hs;
    logic [CNT_W-1:0] single_q;
    logic [CNT_W-1:0] double_q;

    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            single_q <= '0;
            double_q <= '0;
        end else begin
            if (out_hs && out_err_single && (single_q != '1)) begin
                single_q <= single_q + CNT_W'(1);
            end
            if (out_hs && out_err_double && (double_q != '1)) begin
                double_q <= double_q + CNT_W'(1);
            end
        end
    end

    assign err_single_cnt = single_q;
    assign err_double_cnt = double_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign err_single_cnt = '0;
    assign err_double_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder. It encodes words itself, flips chosen codeword positions and scoreboards the decoded output.
module tb_hamming_secded_decoder;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAMMING_ERR_COUNT_EN
    localparam int SAT_EXP = CNT_MAX;
`else
    localparam int SAT_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [5:0]       in_check;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [4:0]       out_syndrome;
    logic             out_err_single;
    logic             out_err_double;
    logic             cnt_clr;
    logic [CNT_W-1:0] err_single_cnt;
    logic [CNT_W-1:0] err_double_cnt;

    hamming_secded_decoder #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_check       (in_check),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_syndrome   (out_syndrome),
        .out_err_single (out_err_single),
        .out_err_double (out_err_double),
        .cnt_clr        (cnt_clr),
        .err_single_cnt (err_single_cnt),
        .err_double_cnt (err_double_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  s;
        logic        sg;
        logic        db;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    int   exp_sc   = 0;
    int   exp_dc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Bit 0 holds overall parity and bits 1..21 hold the codeword positions.
    function automatic logic [21:0] encode(input logic [15:0] d);
        logic [21:0] cw;
        int k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 21; p++) begin
            if (!is_pow2(p)) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            for (int p = 1; p <= 21; p++) begin
                if (!is_pow2(p) && p[i]) cw[1 << i] = cw[1 << i] ^ cw[p];
            end
        end
        cw[0] = ^cw[21:1];
        return cw;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [21:0] flips);
        logic [21:0] rx;
        logic [15:0] rd;
        logic [4:0]  syn;
        exp_t        e;
        int          k;
        int          n;
        int          w;
        rx = encode(d) ^ flips;
        rd = '0;
        k  = 0;
        for (int p = 1; p <= 21; p++) begin
            if (!is_pow2(p)) begin
                rd[k] = rx[p];
                k++;
            end
        end
        syn = '0;
        n   = 0;
        for (int p = 0; p <= 21; p++) begin
            if (flips[p]) begin
                n++;
                syn = syn ^ 5'(p);
            end
        end
        e.s  = syn;
        e.sg = (n == 1);
        e.db = (n >= 2);
        e.d  = (n >= 2) ? rd : d;
        in_data  = rd;
        in_check = {rx[0], rx[16], rx[8], rx[4], rx[2], rx[1]};
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        else sb_q.push_back(e);
        sync();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sb_q.size(), 0);
        sync();
    endtask

    exp_t        mon_e;
    bit          prev_stall = 1'b0;
    logic [15:0] st_data;
    logic [4:0]  st_syn;
    logic        st_sg;
    logic        st_db;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sb_q.delete();
                exp_sc = 0;
                exp_dc = 0;
                prev_stall = 1'b0;
            end else begin
                chk("single_cnt", err_single_cnt, exp_sc);
                chk("double_cnt", err_double_cnt, exp_dc);
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, st_data);
                    chk("stall_syn", out_syndrome, st_syn);
                    chk("stall_flags", {out_err_single, out_err_double}, {st_sg, st_db});
                end
                if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_out", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("out_data", out_data, mon_e.d);
                        chk("out_syndrome", out_syndrome, mon_e.s);
                        chk("out_err_single", out_err_single, mon_e.sg);
                        chk("out_err_double", out_err_double, mon_e.db);
`ifdef HAMMING_ERR_COUNT_EN
                        if (mon_e.sg && exp_sc < CNT_MAX) exp_sc++;
                        if (mon_e.db && exp_dc < CNT_MAX) exp_dc++;
`endif
                    end
                end
                if (cnt_clr) begin
                    exp_sc = 0;
                    exp_dc = 0;
                end
                prev_stall = out_valid && !out_ready;
                st_data = out_data;
                st_syn  = out_syndrome;
                st_sg   = out_err_single;
                st_db   = out_err_double;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int a;
        int b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_check  = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_syndrome", out_syndrome, 0);
        chk("rst_flags", {out_err_single, out_err_double}, 0);
        chk("rst_counters", {err_single_cnt, err_double_cnt}, 0);
        chk("rst_in_ready", in_ready, 1);
        sync();
        rst    = 1'b0;
        mon_en = 1'b1;

        // A clean word becomes valid two edges after it is presented.
        send(16'h811A, 22'd0);
        @(negedge clk);
        chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2", out_valid, 1);
        sync();

        send(16'h811A, 22'(1) << 7);
        send(16'h811A, (22'(1) << 3) | (22'(1) << 5));
        send(16'h5A5A, 22'(1) << 21);
        send(16'h5A5A, 22'(1) << 4);
        send(16'hFFFF, 22'(1));
        send(16'h1234, (22'(1) << 16) | (22'(1) << 8) | (22'(1) << 7));
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            send(d, 22'(1) << $urandom_range(0, 21));
            a = $urandom_range(1, 21);
            b = (a % 21) + 1;
            send(16'($urandom), (22'(1) << a) | (22'(1) << b));
        end
        drain();

        // Back-pressure in the middle of a stream.
        send(16'hA001, 22'd0);
        send(16'hA002, 22'(1) << 9);
        out_ready = 1'b0;
        fork
            begin
                send(16'hA003, 22'd0);
                send(16'hA004, (22'(1) << 1) | (22'(1) << 2));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation, then clear coinciding with an increment.
        cnt_clr = 1'b1;
        sync();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h0F0F + 16'(i), 22'(1) << (3 + i));
        drain();
        @(negedge clk);
        chk("sat_single", err_single_cnt, SAT_EXP);
        sync();
        send(16'h7777, 22'(1) << 10);
        sync();
        cnt_clr = 1'b1;
        sync();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins", err_single_cnt, 0);
        sync();

        // Reset with two words in flight.
        send(16'h3C3C, (22'(1) << 6) | (22'(1) << 12));
        drain();
        send(16'hBEEF, 22'(1) << 11);
        send(16'hCAFE, 22'(1) << 13);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_mid", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_counters", {err_single_cnt, err_double_cnt}, 0);
        sync();
        rst = 1'b0;
        send(16'h1357, 22'd0);
        @(negedge clk);
        chk("post_rst_lat1", out_valid, 0);
        @(negedge clk);
        chk("post_rst_lat2", out_valid, 1);
        sync();
        drain();
        repeat (3) sync();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
